// File: rtl/checker_pkg.sv
// ---------------------------------------------------------------------------
// checker_pkg: shared types for the store-sequence checker.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package checker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    FC_NONE     = 2'd0,
    FC_MISMATCH = 2'd1,
    FC_TIMEOUT  = 2'd2,
    FC_EMPTY    = 2'd3
  } fail_code_t;

  // Counter must hold 0..DEPTH inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/checker_exp_table.sv
// ---------------------------------------------------------------------------
// checker_exp_table: expected (address, data) table with fill count.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module checker_exp_table
  import checker_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int IDX_W  = $clog2(DEPTH),
  parameter int CNT_W  = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o
);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [CNT_W-1:0]  count_q;
  logic              w_push;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign w_push  = we_i && !full_o;
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      count_q <= '0;
    end else if (w_push) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  // Entry storage needs no reset: only indices below count_q are ever read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      addr_q[count_q[IDX_W-1:0]] <= wr_addr_i;
      data_q[count_q[IDX_W-1:0]] <= wr_data_i;
    end
  end

  assign rd_addr_o = addr_q[rd_idx_i];
  assign rd_data_o = data_q[rd_idx_i];

endmodule

`default_nettype wire

// File: rtl/mem_write_checker.sv
// ---------------------------------------------------------------------------
// mem_write_checker: in-order check of CPU stores against an expected table.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_write_checker
  import checker_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 4096,
  parameter int CYC_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 exp_valid,
  input  logic [ADDR_W-1:0]    exp_addr,
  input  logic [DATA_W-1:0]    exp_data,
  input  logic                 ignore_en,
  input  logic [ADDR_W-1:0]    ignore_addr,
  input  logic                 start,
  input  logic                 clear,
  input  logic                 MemWrite,
  input  logic [ADDR_W-1:0]    DataAdr,
  input  logic [DATA_W-1:0]    WriteData,
  output logic                 done,
  output logic                 pass,
  output logic [1:0]           fail_code,
  output logic [ADDR_W-1:0]    fail_addr,
  output logic [DATA_W-1:0]    fail_data,
  output logic [$clog2(DEPTH):0] match_cnt,
  output logic [CYC_W-1:0]     cycles,
  output logic                 load_ovf
);

  localparam int CNT_W = cnt_width(DEPTH);
  localparam int IDX_W = $clog2(DEPTH);

  state_t            state_q;
  fail_code_t        fail_code_q;
  logic              done_q, pass_q, load_ovf_q;
  logic [ADDR_W-1:0] fail_addr_q;
  logic [DATA_W-1:0] fail_data_q;
  logic [CNT_W-1:0]  match_cnt_q;
  logic [CYC_W-1:0]  cycles_q;

  logic [CNT_W-1:0]  w_count, w_cnt_after, w_match_nxt;
  logic [ADDR_W-1:0] w_exp_a;
  logic [DATA_W-1:0] w_exp_d;
  logic              w_full, w_we, w_store, w_hit, w_complete, w_timeout;

  assign w_we        = (state_q == IDLE) && exp_valid;
  assign w_cnt_after = w_count + CNT_W'(w_we && !w_full);
  assign w_store     = (state_q == RUN) && MemWrite &&
                       !(ignore_en && (DataAdr == ignore_addr));
  assign w_hit       = w_store && (DataAdr == w_exp_a) && (WriteData == w_exp_d);
  assign w_match_nxt = match_cnt_q + CNT_W'(1);
  assign w_complete  = w_hit && (w_match_nxt == w_count);
  assign w_timeout   = (cycles_q == CYC_W'(TIMEOUT - 1));

  checker_exp_table #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W),
    .CNT_W  (CNT_W)
  ) u_table (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (clear),
    .we_i      (w_we),
    .wr_addr_i (exp_addr),
    .wr_data_i (exp_data),
    .rd_idx_i  (match_cnt_q[IDX_W-1:0]),
    .rd_addr_o (w_exp_a),
    .rd_data_o (w_exp_d),
    .count_o   (w_count),
    .full_o    (w_full)
  );

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q     <= IDLE;
      fail_code_q <= FC_NONE;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      load_ovf_q  <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      match_cnt_q <= '0;
      cycles_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (exp_valid && w_full) load_ovf_q <= 1'b1;
          if (start) begin
            cycles_q    <= '0;
            match_cnt_q <= '0;
            if (w_cnt_after != '0) begin
              state_q <= RUN;
            end else begin
              state_q     <= FAIL;
              done_q      <= 1'b1;
              fail_code_q <= FC_EMPTY;
            end
          end
        end
        RUN: begin
          if (w_hit) match_cnt_q <= w_match_nxt;
          // cycles freezes on the terminating cycle so it reports that cycle's index.
          if (w_complete) begin
            state_q <= PASS;
            done_q  <= 1'b1;
            pass_q  <= 1'b1;
          end else if (w_store && !w_hit) begin
            state_q     <= FAIL;
            done_q      <= 1'b1;
            fail_code_q <= FC_MISMATCH;
            fail_addr_q <= DataAdr;
            fail_data_q <= WriteData;
          end else if (w_timeout) begin
            state_q     <= FAIL;
            done_q      <= 1'b1;
            fail_code_q <= FC_TIMEOUT;
          end else begin
            cycles_q <= cycles_q + CYC_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_code = fail_code_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;
  assign match_cnt = match_cnt_q;
  assign cycles    = cycles_q;
  assign load_ovf  = load_ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_write_checker.sv
// ---------------------------------------------------------------------------
// tb_mem_write_checker: directed vector table plus multi-cycle corner sequences.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_mem_write_checker;

  localparam int AW = 32, DW = 32, DEPTH = 8, TMO = 16, CW = 16;

  logic          clk = 1'b0;
  logic          reset, exp_valid, ignore_en, start, clear, MemWrite;
  logic [AW-1:0] exp_addr, ignore_addr, DataAdr;
  logic [DW-1:0] exp_data, WriteData;
  logic          done, pass, load_ovf;
  logic [1:0]    fail_code;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_data;
  logic [3:0]    match_cnt;
  logic [CW-1:0] cycles;

  always #5 clk = ~clk;

  mem_write_checker #(
    .ADDR_W (AW), .DATA_W (DW), .DEPTH (DEPTH), .TIMEOUT (TMO), .CYC_W (CW)
  ) dut (
    .clk (clk), .reset (reset), .exp_valid (exp_valid), .exp_addr (exp_addr),
    .exp_data (exp_data), .ignore_en (ignore_en), .ignore_addr (ignore_addr),
    .start (start), .clear (clear), .MemWrite (MemWrite), .DataAdr (DataAdr),
    .WriteData (WriteData), .done (done), .pass (pass), .fail_code (fail_code),
    .fail_addr (fail_addr), .fail_data (fail_data), .match_cnt (match_cnt),
    .cycles (cycles), .load_ovf (load_ovf)
  );

  typedef logic [88:0] obs_t;
  typedef struct packed {
    logic rst, clr, ev; logic [31:0] ea, ed; logic st, mw; logic [31:0] da, wd; logic ign;
  } in_t;
  typedef struct packed { in_t i; obs_t o; } vec_t;

  obs_t act;
  assign act = {done, pass, fail_code, fail_addr, fail_data, match_cnt, cycles, load_ovf};

  int n_applied = 0, n_miscmp = 0;
  vec_t vecs[$];

  function automatic in_t stim(logic rst, logic clr, logic ev, logic [31:0] ea, logic [31:0] ed,
                               logic st, logic mw, logic [31:0] da, logic [31:0] wd, logic ign);
    return '{rst, clr, ev, ea, ed, st, mw, da, wd, ign};
  endfunction

  function automatic obs_t ex(logic d, logic p, logic [1:0] fc, logic [31:0] fa, logic [31:0] fd,
                              logic [3:0] mc, logic [15:0] cyc, logic ovf);
    return {d, p, fc, fa, fd, mc, cyc, ovf};
  endfunction

  task automatic drive(input in_t s);
    reset = s.rst; clear = s.clr; exp_valid = s.ev; exp_addr = s.ea; exp_data = s.ed;
    start = s.st; MemWrite = s.mw; DataAdr = s.da; WriteData = s.wd; ignore_en = s.ign;
  endtask

  task automatic step(input in_t s);
    drive(s);
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input obs_t want);
    n_applied++;
    if (act !== want) begin
      n_miscmp++;
      $display("FAIL %s: got done=%0b pass=%0b fc=%0d fa=%0d fd=%0d mc=%0d cyc=%0d ovf=%0b, want done=%0b pass=%0b fc=%0d fa=%0d fd=%0d mc=%0d cyc=%0d ovf=%0b",
               nm, act[88], act[87], act[86:85], act[84:53], act[52:21], act[20:17], act[16:1], act[0],
               want[88], want[87], want[86:85], want[84:53], want[52:21], want[20:17], want[16:1], want[0]);
    end
  endtask

  in_t  NOP, CLR;
  obs_t Z;

  initial begin
    NOP = stim(0,0,0,0,0,0,0,0,0,0);
    CLR = stim(0,1,0,0,0,0,0,0,0,0);
    Z   = ex(0,0,0,0,0,0,0,0);
    ignore_addr = 32'd96;
    drive(NOP);

    // Legacy program: ignored scratch stores, then the real result store.
    vecs.push_back('{stim(1,0,0,0,0,0,0,0,0,0),        Z});
    vecs.push_back('{stim(0,0,1,100,25,0,0,0,0,1),     Z});
    vecs.push_back('{stim(0,0,0,0,0,1,0,0,0,1),        Z});
    vecs.push_back('{stim(0,0,0,0,0,0,1,96,7,1),       ex(0,0,0,0,0,0,1,0)});
    vecs.push_back('{stim(0,0,0,0,0,0,1,96,25,1),      ex(0,0,0,0,0,0,2,0)});
    vecs.push_back('{stim(0,0,0,0,0,0,1,100,25,1),     ex(1,1,0,0,0,1,2,0)});
    vecs.push_back('{stim(0,0,0,0,0,0,1,100,99,0),     ex(1,1,0,0,0,1,2,0)});
    vecs.push_back('{CLR,                              Z});
    // Mismatch on second store.
    vecs.push_back('{stim(0,0,1,100,25,0,0,0,0,0),     Z});
    vecs.push_back('{stim(0,0,1,104,3,0,0,0,0,0),      Z});
    vecs.push_back('{stim(0,0,0,0,0,1,0,0,0,0),        Z});
    vecs.push_back('{stim(0,0,0,0,0,0,1,100,25,0),     ex(0,0,0,0,0,1,1,0)});
    vecs.push_back('{stim(0,0,0,0,0,0,1,104,4,0),      ex(1,0,1,104,4,1,1,0)});
    vecs.push_back('{NOP,                              ex(1,0,1,104,4,1,1,0)});
    vecs.push_back('{CLR,                              Z});
    // Empty table after clear.
    vecs.push_back('{stim(0,0,0,0,0,1,0,0,0,0),        ex(1,0,3,0,0,0,0,0)});
    vecs.push_back('{CLR,                              Z});
    // Load and start together; exp_valid during RUN must not grow the table.
    vecs.push_back('{stim(0,0,1,200,1,1,0,0,0,0),      Z});
    vecs.push_back('{stim(0,0,1,201,2,0,1,200,1,0),    ex(1,1,0,0,0,1,0,0)});
    vecs.push_back('{CLR,                              Z});
    // Ignored store equal to expected entry has no effect.
    vecs.push_back('{stim(0,0,1,96,5,0,0,0,0,0),       Z});
    vecs.push_back('{stim(0,0,0,0,0,1,0,0,0,1),        Z});
    vecs.push_back('{stim(0,0,0,0,0,0,1,96,5,1),       ex(0,0,0,0,0,0,1,0)});
    vecs.push_back('{stim(0,0,0,0,0,0,1,96,6,0),       ex(1,0,1,96,6,0,1,0)});
    vecs.push_back('{CLR,                              Z});

    for (int k = 0; k < vecs.size(); k++) begin
      step(vecs[k].i);
      check($sformatf("vec%0d", k), vecs[k].o);
    end

    // Timeout with no stores, then held for 20 cycles despite traffic.
    step(stim(0,0,1,500,1,0,0,0,0,0));
    step(stim(0,0,0,0,0,1,0,0,0,0));
    for (int k = 1; k <= 15; k++) step(NOP);
    check("to_pre", ex(0,0,0,0,0,0,15,0));
    step(NOP);
    check("to_fire", ex(1,0,2,0,0,0,15,0));
    for (int k = 0; k < 20; k++) begin
      step(stim(0,0,1,$urandom,$urandom,1,1,$urandom,$urandom,0));
      check($sformatf("to_hold%0d", k), ex(1,0,2,0,0,0,15,0));
    end
    step(CLR);

    // Completing match on the last allowed cycle wins over timeout.
    step(stim(0,0,1,600,2,0,0,0,0,0));
    step(stim(0,0,0,0,0,1,0,0,0,0));
    for (int k = 1; k <= 15; k++) step(NOP);
    step(stim(0,0,0,0,0,0,1,600,2,0));
    check("edge_pass", ex(1,1,0,0,0,1,15,0));
    step(CLR);
    check("clr_pass", Z);

    // Overflow: ninth entry dropped and never checked.
    for (int k = 0; k < 9; k++) begin
      step(stim(0,0,1,32'h1000 + 4*k,k+1,0,0,0,0,0));
      if (k == 7) check("ovf_8", Z);
      if (k == 8) check("ovf_9", ex(0,0,0,0,0,0,0,1));
    end
    step(stim(0,0,0,0,0,1,0,0,0,0));
    for (int k = 0; k < 8; k++) begin
      step(stim(0,0,0,0,0,0,1,32'h1000 + 4*k,k+1,0));
      if (k == 3) check("ovf_mid", ex(0,0,0,0,0,4,4,1));
    end
    check("ovf_pass", ex(1,1,0,0,0,8,7,1));
    step(CLR);
    check("ovf_clr", Z);

    // Reset mid-RUN aborts silently and empties the table.
    step(stim(0,0,1,700,1,0,0,0,0,0));
    step(stim(0,0,1,704,2,0,0,0,0,0));
    step(stim(0,0,0,0,0,1,0,0,0,0));
    step(stim(0,0,0,0,0,0,1,700,1,0));
    check("rst_pre", ex(0,0,0,0,0,1,1,0));
    step(stim(1,0,0,0,0,0,0,0,0,0));
    check("rst_mid", Z);
    step(stim(0,0,0,0,0,1,0,0,0,0));
    check("rst_empty", ex(1,0,3,0,0,0,0,0));
    step(CLR);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscmp);
    $finish;
  end

endmodule

`default_nettype wire
